// File: rtl/hfu_pkg.sv
// hfu_pkg -- shared definitions for the forwarding / hazard unit.
//   FWD_*        : encoding of one 2-bit forwarding select
//   hfu_state_t  : multiply-tracking FSM state
package hfu_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;  // operand read from the register file
  localparam logic [1:0] FWD_EXMEM = 2'b01;  // operand from the EX/MEM pipeline register
  localparam logic [1:0] FWD_MEMWB = 2'b10;  // operand from the MEM/WB pipeline register
  localparam logic [1:0] FWD_WBH   = 2'b11;  // operand from the WB history register

  typedef logic [0:0] hfu_state_t;
  localparam hfu_state_t ST_IDLE     = 1'b0;
  localparam hfu_state_t ST_MUL_BUSY = 1'b1;

endpackage

// File: rtl/hazard_forward_unit_if.sv
// hazard_forward_unit_if -- pipeline-to-hazard-unit bundle.
//   master : pipeline side (drives ID/EX/MEM/WB status, receives controls)
//   slave  : hazard_forward_unit side
//   id_rs packs operand i at [i*REG_AW +: REG_AW]; fwd_sel packs operand i at [2i +: 2].
interface hazard_forward_unit_if #(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5
);
  logic                      id_valid;
  logic [NUM_SRC*REG_AW-1:0] id_rs;
  logic                      id_is_mul;
  logic                      ex_regwrite;
  logic                      ex_memread;
  logic                      ex_mul_start;
  logic [REG_AW-1:0]         ex_rd;
  logic                      mem_regwrite;
  logic [REG_AW-1:0]         mem_rd;
  logic                      wb_regwrite;
  logic [REG_AW-1:0]         wb_rd;
  logic [2*NUM_SRC-1:0]      fwd_sel;
  logic                      stall;
  logic                      flush_ex;
  logic                      mul_busy;

  modport master (
    output id_valid, id_rs, id_is_mul,
    output ex_regwrite, ex_memread, ex_mul_start, ex_rd,
    output mem_regwrite, mem_rd, wb_regwrite, wb_rd,
    input  fwd_sel, stall, flush_ex, mul_busy
  );

  modport slave (
    input  id_valid, id_rs, id_is_mul,
    input  ex_regwrite, ex_memread, ex_mul_start, ex_rd,
    input  mem_regwrite, mem_rd, wb_regwrite, wb_rd,
    output fwd_sel, stall, flush_ex, mul_busy
  );
endinterface

// File: rtl/hfu_operand_match.sv
// hfu_operand_match -- priority comparator for one source operand.
//   rs                      : source register in decode
//   ex_*/mem_*/wb_*         : producers further down the pipe
//   mul_rd                  : destination of the in-flight multiply
//   sel                     : forwarding select (EX beats MEM beats WB history)
//   load_hit                : operand depends on the load now in EX
//   mul_hit                 : operand depends on the in-flight multiply
// Optional feature macro: HFU_WB_BYPASS_EN enables the WB history select.
module hfu_operand_match
  import hfu_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [REG_AW-1:0] mul_rd,
  output logic [1:0]        sel,
  output logic              load_hit,
  output logic              mul_hit
);

  // x0 is hard-wired zero, so it never depends on anything.
  logic rs_nz;
  logic ex_hit;
  logic mem_hit;

  assign rs_nz   = (rs != '0);
  assign ex_hit  = rs_nz && ex_regwrite  && (ex_rd  == rs);
  assign mem_hit = rs_nz && mem_regwrite && (mem_rd == rs);

`ifdef HFU_WB_BYPASS_EN
  logic wb_hit;
  assign wb_hit = rs_nz && wb_regwrite && (wb_rd == rs);
`else
  // Write-before-read regfile: WB producers need no bypass.
  logic unused_wb;
  assign unused_wb = wb_regwrite ^ (^wb_rd);
`endif

  always_comb begin
    sel = FWD_RF;
    if (ex_hit) begin
      sel = FWD_EXMEM;
    end else if (mem_hit) begin
      sel = FWD_MEMWB;
`ifdef HFU_WB_BYPASS_EN
    end else if (wb_hit) begin
      sel = FWD_WBH;
`endif
    end
  end

  assign load_hit = rs_nz && ex_memread && (ex_rd == rs);
  // rs_nz also guarantees a zero mul_rd never matches.
  assign mul_hit  = rs_nz && (mul_rd == rs);

endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit -- forwarding selects, load-use and multiply hazards.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   bus        : hazard_forward_unit_if.slave
//     fwd_sel  : registered selects for the instruction now in EX
//     stall    : hold PC and IF/ID (combinational)
//     flush_ex : bubble into ID/EX (always equal to stall)
//     mul_busy : a multiply is still in flight
// Optional feature macro: HFU_WB_BYPASS_EN (WB history select 11).
module hazard_forward_unit
  import hfu_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  hazard_forward_unit_if.slave bus
);

  localparam int CNT_W = $clog2(MUL_LAT) + 1;

  logic [2*NUM_SRC-1:0] sel_vec;
  logic [NUM_SRC-1:0]   load_vec;
  logic [NUM_SRC-1:0]   mul_vec;

  hfu_state_t           state_q,   state_d;
  logic [CNT_W-1:0]     cnt_q,     cnt_d;
  logic [REG_AW-1:0]    mul_rd_q,  mul_rd_d;
  logic [2*NUM_SRC-1:0] fwd_sel_q, fwd_sel_d;
  logic                 stall;
  logic                 busy;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    hfu_operand_match #(.REG_AW(REG_AW)) u_match (
      .rs           (bus.id_rs[i*REG_AW +: REG_AW]),
      .ex_regwrite  (bus.ex_regwrite),
      .ex_memread   (bus.ex_memread),
      .ex_rd        (bus.ex_rd),
      .mem_regwrite (bus.mem_regwrite),
      .mem_rd       (bus.mem_rd),
      .wb_regwrite  (bus.wb_regwrite),
      .wb_rd        (bus.wb_rd),
      .mul_rd       (mul_rd_q),
      .sel          (sel_vec[2*i +: 2]),
      .load_hit     (load_vec[i]),
      .mul_hit      (mul_vec[i])
    );
  end

  assign busy = (state_q == ST_MUL_BUSY);

  // Load-use and multiply hazards OR together, so coincident causes still
  // produce a single stall cycle.
  always_comb begin
    stall = 1'b0;
    if (bus.id_valid) begin
      stall = (|load_vec) || (busy && (bus.id_is_mul || (|mul_vec)));
    end
  end

  // A stalled or empty decode slot becomes a bubble in EX.
  always_comb begin
    fwd_sel_d = sel_vec;
    if (stall || !bus.id_valid) begin
      fwd_sel_d = '0;
    end
  end

  // Multiply tracker: cnt counts down the remaining busy cycles; the last
  // busy cycle is the one where cnt reaches 1. A start while busy cannot
  // occur (the dependent multiply is stalled) and is ignored.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mul_rd_d = mul_rd_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.ex_mul_start) begin
          state_d  = ST_MUL_BUSY;
          cnt_d    = CNT_W'(MUL_LAT - 1);
          mul_rd_d = bus.ex_rd;
        end
      end
      default: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      mul_rd_q  <= '0;
      fwd_sel_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mul_rd_q  <= mul_rd_d;
      fwd_sel_q <= fwd_sel_d;
    end
  end

  assign bus.fwd_sel  = fwd_sel_q;
  assign bus.stall    = stall;
  assign bus.flush_ex = stall;
  assign bus.mul_busy = busy;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit (NUM_SRC=2, REG_AW=5, MUL_LAT=3).
// Each vector carries hand-computed stall/busy/fwd expectations that pin a
// behavioural model; the model is compared with the DUT every cycle.
module tb_hazard_forward_unit;

  localparam int NUM_SRC = 2;
  localparam int REG_AW  = 5;
  localparam int MUL_LAT = 3;
`ifdef HFU_WB_BYPASS_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hazard_forward_unit_if #(.NUM_SRC(NUM_SRC), .REG_AW(REG_AW)) bus ();

  hazard_forward_unit #(.NUM_SRC(NUM_SRC), .REG_AW(REG_AW), .MUL_LAT(MUL_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit       rst;
    bit       valid;
    int       rs1;
    int       rs2;
    bit       is_mul;
    bit       ex_rw;
    bit       ex_mr;
    bit       ex_ms;
    int       ex_rd;
    bit       mem_rw;
    int       mem_rd;
    bit       wb_rw;
    int       wb_rd;
    bit       e_stall;
    bit       e_busy;
    bit [3:0] e_fwd;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: cycle index, cycle at which the tracked multiply was in EX.
  int   cyc = 0;
  int   issue_cyc = -1000;
  int   mul_rd_m = 0;

  function automatic vec_t mk(bit rst, bit valid, int rs1, int rs2, bit is_mul,
                              bit ex_rw, bit ex_mr, bit ex_ms, int ex_rd,
                              bit mem_rw, int mem_rd, bit wb_rw, int wb_rd,
                              bit e_stall, bit e_busy, bit [3:0] e_fwd);
    vec_t v;
    v.rst = rst; v.valid = valid; v.rs1 = rs1; v.rs2 = rs2; v.is_mul = is_mul;
    v.ex_rw = ex_rw; v.ex_mr = ex_mr; v.ex_ms = ex_ms; v.ex_rd = ex_rd;
    v.mem_rw = mem_rw; v.mem_rd = mem_rd; v.wb_rw = wb_rw; v.wb_rd = wb_rd;
    v.e_stall = e_stall; v.e_busy = e_busy; v.e_fwd = e_fwd;
    return v;
  endfunction

  function automatic bit m_busy();
    return (cyc > issue_cyc) && (cyc <= issue_cyc + MUL_LAT - 1);
  endfunction

  function automatic bit [1:0] m_sel(vec_t v, int rs);
    if (rs == 0) return 2'd0;
    if (v.ex_rw && v.ex_rd == rs) return 2'd1;
    if (v.mem_rw && v.mem_rd == rs) return 2'd2;
    if (WB_EN && v.wb_rw && v.wb_rd == rs) return 2'd3;
    return 2'd0;
  endfunction

  function automatic bit m_stall(vec_t v);
    bit load_dep, mul_dep;
    if (v.rst || !v.valid) return 1'b0;
    load_dep = v.ex_mr && v.ex_rd != 0 && (v.ex_rd == v.rs1 || v.ex_rd == v.rs2);
    mul_dep  = m_busy() && (v.is_mul ||
               (mul_rd_m != 0 && (mul_rd_m == v.rs1 || mul_rd_m == v.rs2)));
    return load_dep || mul_dep;
  endfunction

  function automatic bit [3:0] m_fwd(vec_t v);
    if (v.rst || !v.valid || m_stall(v)) return 4'd0;
    return {m_sel(v, v.rs2), m_sel(v, v.rs1)};
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec%0d actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(vec_t v);
    reset            = v.rst;
    bus.id_valid     = v.valid;
    bus.id_rs        = {REG_AW'(v.rs2), REG_AW'(v.rs1)};
    bus.id_is_mul    = v.is_mul;
    bus.ex_regwrite  = v.ex_rw;
    bus.ex_memread   = v.ex_mr;
    bus.ex_mul_start = v.ex_ms;
    bus.ex_rd        = REG_AW'(v.ex_rd);
    bus.mem_regwrite = v.mem_rw;
    bus.mem_rd       = REG_AW'(v.mem_rd);
    bus.wb_regwrite  = v.wb_rw;
    bus.wb_rd        = REG_AW'(v.wb_rd);
  endtask

  initial begin
    //            rst val rs1 rs2 mul exw exm exs exd mw md ww wd  stall busy fwd
    vecs.push_back(mk(1, 0,  0,  0, 0,  0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 4'b0000)); // 0 reset
    vecs.push_back(mk(0, 1,  3,  4, 0,  1,  0,  0,  3, 0, 0, 0, 0, 0, 0, 4'b0001)); // 1 add x3 -> rs1 01
    vecs.push_back(mk(0, 1,  1,  5, 0,  1,  1,  0,  5, 0, 0, 0, 0, 1, 0, 4'b0000)); // 2 lw x5 load-use
    vecs.push_back(mk(0, 1,  1,  5, 0,  0,  0,  0,  0, 1, 5, 0, 0, 0, 0, 4'b1000)); // 3 load in MEM -> rs2 10
    vecs.push_back(mk(0, 1,  0,  0, 0,  1,  1,  0,  0, 1, 0, 0, 0, 0, 0, 4'b0000)); // 4 x0 never matches
    vecs.push_back(mk(0, 1,  6,  8, 0,  1,  0,  0,  6, 1, 8, 0, 0, 0, 0, 4'b1001)); // 5 per-operand selects
    vecs.push_back(mk(0, 1,  6,  2, 0,  1,  0,  0,  6, 1, 6, 0, 0, 0, 0, 4'b0001)); // 6 EX beats MEM
    vecs.push_back(mk(0, 1,  9,  0, 0,  0,  0,  0,  0, 0, 0, 1, 9, 0, 0,
                      WB_EN ? 4'b0011 : 4'b0000));                                  // 7 WB-only match
    vecs.push_back(mk(0, 1, 10,  9, 0,  0,  0,  0,  0, 1,10, 1,10, 0, 0, 4'b0010)); // 8 MEM beats WB
    vecs.push_back(mk(0, 1,  1,  2, 0,  1,  0,  1,  7, 0, 0, 0, 0, 0, 0, 4'b0000)); // 9 mul x7 at N
    vecs.push_back(mk(0, 1,  7,  0, 0,  0,  0,  0,  0, 1, 7, 0, 0, 1, 1, 4'b0000)); // 10 N+1 dep stalls
    vecs.push_back(mk(0, 1,  2,  3, 1,  0,  0,  0,  0, 0, 0, 0, 0, 1, 1, 4'b0000)); // 11 N+2 mul stalls
    vecs.push_back(mk(0, 1,  7,  0, 0,  0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 4'b0000)); // 12 N+3 released
    vecs.push_back(mk(0, 1,  0,  0, 0,  1,  0,  1, 12, 0, 0, 0, 0, 0, 0, 4'b0000)); // 13 mul x12
    vecs.push_back(mk(0, 1,  1, 12, 0,  1,  1,  0,  1, 0, 0, 0, 0, 1, 1, 4'b0000)); // 14 load + mul stall
    vecs.push_back(mk(1, 1, 12,  0, 0,  0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 4'b0000)); // 15 reset mid-mul
    vecs.push_back(mk(0, 1, 12,  0, 0,  0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 4'b0000)); // 16 tracking gone
    vecs.push_back(mk(0, 0,  0,  0, 0,  1,  0,  1,  0, 0, 0, 0, 0, 0, 0, 4'b0000)); // 17 mul x0
    vecs.push_back(mk(0, 1,  0,  5, 0,  0,  0,  0,  0, 0, 0, 0, 0, 0, 1, 4'b0000)); // 18 x0 dest no stall
    vecs.push_back(mk(0, 1,  0,  0, 1,  0,  0,  0,  0, 0, 0, 0, 0, 1, 1, 4'b0000)); // 19 mul while busy
    vecs.push_back(mk(0, 1,  0,  0, 1,  0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 4'b0000)); // 20 busy over
    vecs.push_back(mk(0, 0,  3,  0, 0,  1,  1,  0,  3, 0, 0, 0, 0, 0, 0, 4'b0000)); // 21 id invalid

    apply(vecs[0]);
    foreach (vecs[k]) begin
      vec_t     v;
      bit       es, eb;
      bit [3:0] ef;
      v = vecs[k];
      @(negedge clk);
      apply(v);
      #1;
      es = m_stall(v);
      eb = v.rst ? 1'b0 : m_busy();
      ef = m_fwd(v);
      chk("model_stall", k, 32'(es), 32'(v.e_stall));
      chk("model_busy",  k, 32'(eb), 32'(v.e_busy));
      chk("model_fwd",   k, 32'(ef), 32'(v.e_fwd));
      chk("stall",    k, 32'(bus.stall),    32'(es));
      chk("flush_ex", k, 32'(bus.flush_ex), 32'(es));
      chk("mul_busy", k, 32'(bus.mul_busy), 32'(eb));
      if (v.rst) chk("fwd_in_reset", k, 32'(bus.fwd_sel), 32'd0);
      @(posedge clk);
      if (v.rst) begin
        issue_cyc = -1000;
        mul_rd_m  = 0;
      end else if (v.ex_ms && !m_busy()) begin
        issue_cyc = cyc;
        mul_rd_m  = v.ex_rd;
      end
      cyc++;
      #1;
      chk("fwd_sel", k, 32'(bus.fwd_sel), 32'(ef));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Parametrised forwarding and hazard unit for the 5-stage pipeline. Computes per-operand forwarding selects in decode and registers them for use in execute, detects load-use hazards, and tracks one in-flight multi-cycle multiply with a busy counter. Drives the ID/EX stall and bubble controls. Serves any number of source operands.

## Interface
- NUM_SRC, 2, number of source operands checked per instruction
- REG_AW, 5, register address width
- MUL_LAT, 3, multiply latency in cycles (≥2)
- clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-high reset
- id_valid  input  1  decode stage holds a real instruction
- id_rs  input  NUM_SRC*REG_AW  decode source registers; operand i in bits [i*REG_AW +: REG_AW]
- id_is_mul  input  1  decode instruction is a multiply
- ex_regwrite, ex_memread, ex_mul_start  input  1 each  execute-stage write enable, load, multiply issue
- ex_rd  input  REG_AW  execute-stage destination
- mem_regwrite  input  1, mem_rd  input  REG_AW  memory-stage write
- wb_regwrite  input  1, wb_rd  input  REG_AW  writeback-stage write
- fwd_sel  output  2*NUM_SRC  registered selects for the instruction now in EX; operand i in [2i +: 2]; 00 regfile, 01 EX/MEM, 10 MEM/WB, 11 WB history
- stall  output  1  hold PC and IF/ID this cycle
- flush_ex  output  1  insert bubble into ID/EX this cycle
- mul_busy  output  1  multiply in flight

## Operation
- Register address 0 never matches.
- Per operand, in decode priority order: ex_regwrite && ex_rd==rs → 01 (producer is in MEM when consumer is in EX); else mem_regwrite && mem_rd==rs → 10; else 00.
- Load-use: id_valid && ex_memread && ex_rd==any rs → stall=1, flush_ex=1. The consumer re-evaluates next cycle and sees the load in MEM → 10.
- FSM states IDLE, MUL_BUSY. IDLE→MUL_BUSY on ex_mul_start; this captures mul_rd=ex_rd and sets cnt=MUL_LAT-1. In MUL_BUSY, cnt decrements each cycle. When cnt==1, the next state is IDLE. ex_mul_start while busy is illegal; it is prevented by the stall.
- In MUL_BUSY: stall=flush_ex=1 if id_valid && (id_is_mul || any rs==mul_rd, mul_rd≠0).
- stall and flush_ex are always equal.
- stall and flush_ex are combinational from inputs plus state. fwd_sel is registered.
- When stall=1 or id_valid=0, fwd_sel loads all 00 (a bubble enters EX).

## Timing
- Reset: fwd_sel=0, stall=0, flush_ex=0, mul_busy=0, state IDLE, cnt=0, mul_rd=0. Reset mid-multiply abandons tracking immediately.
- fwd_sel latency: computed in cycle N (consumer in ID), valid through cycle N+1 (consumer in EX).
- Load-use costs exactly 1 stall cycle.
- Multiply issued in EX at cycle N: mul_busy=1 for cycles N+1 … N+MUL_LAT-1, and dependents stall for those cycles. Load-use and multiply stall in the same cycle still produce a single stall.
- EX and MEM both match the same operand → the younger producer (01) wins.
- Different operands may receive different selects in the same cycle.

## Configuration
- HFU_WB_BYPASS_EN defined: for a regfile without write-through, wb_regwrite && wb_rd==rs with no EX/MEM match → 11 (WB history register in the datapath).
- Undefined: 11 is never produced; the regfile is write-before-read.

## Structure
- Shared package `hfu_pkg`: fwd_sel encoding constants (FWD_RF, FWD_EXMEM, FWD_MEMWB, FWD_WBH), FSM state typedef.
- One sub-module, `hfu_operand_match`: the per-operand priority comparator, instantiated NUM_SRC times via generate.

## Test plan
- add x3 in EX, consumer rs1=x3 in ID → next cycle fwd_sel[1:0]=01, stall=0.
- lw x5 in EX, consumer rs2=x5 → stall=flush_ex=1 for one cycle, then fwd_sel[3:2]=10.
- rs1=x0 with ex_rd=x0 and ex_regwrite=1 → fwd_sel=00, no stall.
- MUL_LAT=3, mul x7 issued at N, consumer rs1=x7 → stall at N+1 and N+2, released at N+3; a second mul at N+1 also stalls.
- Reset asserted at N+1 of a multiply → mul_busy=0 and stall=0 immediately, all outputs 0.
- HFU_WB_BYPASS_EN defined, wb_rd=x9 only match → 11; undefined → 00.
